regfile_writeback: RTL
======================

// Module: regfile_writeback
// PURPOSE
//  Writeback stage that drives the write port of RegisterFile (writeEnable/rd/writerData).
//  Merges results from two producers, the single-cycle ALU and the load unit, into one write per cycle.
//  Extends load data by funct3 (byte offset, sign/zero extension) and suppresses x0 writes.
//  Counts retired register writes.
// PARAMETERS
//  N      64   datapath width; only 64 is supported (RV64); elaboration $error otherwise
//  CNT_W  32   width of wb_count
// PORTS
//  clk          in   1      clock, all state on posedge
//  reset        in   1      asynchronous, active-high reset
//  alu_valid    in   1      ALU result present
//  alu_ready    out  1      ALU result accepted when alu_valid & alu_ready
//  alu_rd       in   5      ALU destination register
//  alu_data     in   N      ALU result
//  ld_valid     in   1      load result present
//  ld_ready     out  1      load result accepted when ld_valid & ld_ready
//  ld_rd        in   5      load destination register
//  ld_funct3    in   3      000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU, 111 = LD
//  ld_offset    in   3      byte address bits [2:0] of the load
//  ld_rdata     in   N      aligned 64-bit doubleword read from memory
//  writeEnable  out  1      to RegisterFile
//  rd           out  5      to RegisterFile
//  writerData   out  N      to RegisterFile
//  wb_count     out  CNT_W  number of cycles with writeEnable=1; wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (async): writeEnable=0, rd=0, writerData=0, wb_count=0, skid empty.
//    Asserting reset mid-operation discards the skid entry and any pending write.
//  - Outputs writeEnable/rd/writerData are registered.
//    A result accepted at posedge k drives writeEnable=1 during cycle k..k+1.
//    RegisterFile commits it at posedge k+1.
//  - One-entry ALU skid buffer {rd,data}. skid_full is registered.
//    alu_ready = ld_ready = ~skid_full (combinational from state only, never from valids).
//  - Per-cycle selection for the output register:
//    * skid_full: write skid entry; accept nothing; skid empties.
//    * skid empty, ld_valid: write load.
//      If alu_valid is also high, accept ALU into skid, unless alu_rd==0, which is accepted and dropped.
//    * skid empty, only alu_valid: write ALU directly (skid bypass).
//    * nothing selected: writeEnable=0; rd/writerData hold.
//  - Ordering: the load wins over a simultaneous ALU result. No starvation; worst case is 2 cycles per pair.
//  - x0: a handshake with rd==0 is accepted normally, but writeEnable stays 0 and wb_count does not increment.
//  - Load extension:
//    * Effective offset = ld_offset & ~(size-1); sub-size offset bits are ignored (misalignment is the load unit's job).
//    * shifted = ld_rdata >> (8*effective_offset).
//    * Size is 8/16/32/64 bits.
//    * Signed ops replicate bit size-1 into [63:size]; U ops zero-fill.
//  - wb_count increments on every cycle where the registered writeEnable becomes 1. At all-ones it wraps to 0.
// STRUCTURE
//  - rv64_pkg:
//    * localparams F3_LB..F3_LWU
//    * typedef struct packed {logic [4:0] rd; logic [63:0] data;} wb_req_t (skid and output register)
//  - Sub-module load_extend (combinational): funct3, offset, rdata -> extended data.
//  - Top module: skid register, selection mux, output register, counter.
// TESTING
//  1. Reset mid-stream: with skid full, pulse reset -> writeEnable=0, rd=0, writerData=0, wb_count=0;
//     the next cycle shows alu_ready=1.
//  2. ALU alone: alu_rd=1, data=0xA1 -> writeEnable=1, rd=1, writerData=0xA1 one cycle later;
//     RegisterFile read of x1 returns 0xA1.
//  3. Collision: ld (rd=2, LD, rdata=0xB2) and alu (rd=3, 0xC3) in the same cycle ->
//     cycle+1 writes x2=0xB2; cycle+2 writes x3=0xC3; alu_ready/ld_ready low during cycle+1; wb_count +2.
//  4. Extension: rdata=0x8070_6050_4030_2010_FF80 (low 64 bits) with:
//     * LB off=1 -> 0xFFFF_FFFF_FFFF_FFFF
//     * LBU off=0 -> 0x80
//     * LH off=3 (eff 2) -> 0x2010 sign-extended
//     * LWU off=4 -> zero-extended upper word
//  5. x0 suppression: alu_rd=0, data=0xFFFF_FFFF_FFFF_FFFF accepted -> writeEnable stays 0;
//     wb_count unchanged; x0 still reads 0.
//  6. Back-to-back: 8 ALU results on consecutive cycles -> 8 consecutive writes, no stall;
//     wb_count preloaded via 2^CNT_W-4 writes (CNT_W=4 build) wraps to 4.

Source files
------------

// File: rtl/rv64_pkg.sv
// Shared RV64 writeback types: load funct3 encodings and the {rd,data} write request.
package rv64_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] data;
   } wb_req_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load alignment and sign/zero extension of a 64-bit doubleword by funct3/offset.
module load_extend
   import rv64_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [2:0]  offset,
   input  logic [63:0] rdata,
   output logic [63:0] data
);

   logic [2:0]  eff;
   logic [63:0] shifted;

   // Offset bits below the access size are dropped; alignment faults are handled upstream.
   always_comb begin
      eff = offset;
      case (funct3[1:0])
         2'b00:   eff = offset;
         2'b01:   eff = {offset[2:1], 1'b0};
         2'b10:   eff = {offset[2], 2'b00};
         default: eff = 3'b000;
      endcase
   end

   assign shifted = rdata >> {eff, 3'b000};

   always_comb begin
      data = shifted;
      case (funct3)
         F3_LB:   data = {{56{shifted[7]}},  shifted[7:0]};
         F3_LH:   data = {{48{shifted[15]}}, shifted[15:0]};
         F3_LW:   data = {{32{shifted[31]}}, shifted[31:0]};
         F3_LBU:  data = {56'd0, shifted[7:0]};
         F3_LHU:  data = {48'd0, shifted[15:0]};
         F3_LWU:  data = {32'd0, shifted[31:0]};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and load results into one registered RegisterFile write per cycle (1-cycle latency).
// A colliding ALU result parks in a one-entry skid; both readies drop while it is full.
module regfile_writeback
   import rv64_pkg::*;
#(
   parameter int N     = 64,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alu_valid,
   output logic             alu_ready,
   input  logic [4:0]       alu_rd,
   input  logic [N-1:0]     alu_data,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [4:0]       ld_rd,
   input  logic [2:0]       ld_funct3,
   input  logic [2:0]       ld_offset,
   input  logic [N-1:0]     ld_rdata,
   output logic             writeEnable,
   output logic [4:0]       rd,
   output logic [N-1:0]     writerData,
   output logic [CNT_W-1:0] wb_count
);

   if (N != 64) begin : g_bad_width
      $error("regfile_writeback supports only N=64");
   end

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   wb_req_t          skid_q;
   wb_req_t          out_q;
   wb_req_t          alu_req;
   wb_req_t          ld_req;
   wb_req_t          sel;
   logic             skid_full;
   logic             sel_vld;
   logic             wr;
   logic             skid_load;
   logic             we_q;
   logic [CNT_W-1:0] cnt_q;
   logic [63:0]      ld_ext;

   load_extend u_load_extend (
      .funct3 (ld_funct3),
      .offset (ld_offset),
      .rdata  (ld_rdata),
      .data   (ld_ext)
   );

   assign alu_req = '{rd: alu_rd, data: alu_data};
   assign ld_req  = '{rd: ld_rd,  data: ld_ext};

   // Priority: parked ALU result, then load, then ALU bypass.
   always_comb begin
      sel     = skid_q;
      sel_vld = 1'b0;
      if (skid_full) begin
         sel     = skid_q;
         sel_vld = 1'b1;
      end else if (ld_valid) begin
         sel     = ld_req;
         sel_vld = 1'b1;
      end else if (alu_valid) begin
         sel     = alu_req;
         sel_vld = 1'b1;
      end
   end

   assign wr        = sel_vld && (sel.rd != 5'd0);
   assign skid_load = !skid_full && ld_valid && alu_valid && (alu_rd != 5'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         skid_q    <= '0;
         skid_full <= 1'b0;
         out_q     <= '0;
         we_q      <= 1'b0;
         cnt_q     <= '0;
      end else begin
         we_q <= wr;
         if (wr) begin
            out_q <= sel;
            cnt_q <= cnt_q + CNT_ONE;
         end
         if (skid_full) begin
            skid_full <= 1'b0;
         end else if (skid_load) begin
            skid_full <= 1'b1;
            skid_q    <= alu_req;
         end
      end
   end

   assign alu_ready   = !skid_full;
   assign ld_ready    = !skid_full;
   assign writeEnable = we_q;
   assign rd          = out_q.rd;
   assign writerData  = out_q.data;
   assign wb_count    = cnt_q;

endmodule
